// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control stage for the RV32 ID/EX boundary.
// Decodes ALUOp/funct3/funct7 into an operation code and sequences the
// multi-cycle MUL*/DIV*/REM* unit, holding off issue while it runs.
// Optional feature macro: ALU_CTRL_M_EXT_EN (M-extension decode and sequencing).
// Without it, funct7=0000001 decodes illegal and the FSM never leaves IDLE.
module alu_ctrl_seq #(
    parameter int OP_W       = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            is_imm,
    input  logic            flush,
    output logic            op_valid,
    output logic [OP_W-1:0] operation,
    output logic            illegal,
    output logic            mc_start,
    output logic            stall
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    // A one-cycle multiplier completes like any other single-cycle op.
    localparam logic MUL_MULTI = (MUL_CYCLES > 1);

    localparam logic [4:0] OP_AND  = 5'h00, OP_OR   = 5'h01, OP_ADD  = 5'h02;
    localparam logic [4:0] OP_XOR  = 5'h03, OP_SUB  = 5'h04, OP_SRL  = 5'h05;
    localparam logic [4:0] OP_SLL  = 5'h06, OP_SRA  = 5'h07, OP_BEQ  = 5'h08;
    localparam logic [4:0] OP_BLT  = 5'h09, OP_BGE  = 5'h0A, OP_BNE  = 5'h0B;
    localparam logic [4:0] OP_SLT  = 5'h0C, OP_PASS = 5'h0D, OP_BLTU = 5'h0E;
    localparam logic [4:0] OP_BGEU = 5'h0F, OP_SLTU = 5'h18, OP_ILL  = 5'h1F;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mc_start_q, mc_start_d;
    logic             op_valid_q, op_valid_d;
    logic [4:0]       operation_q, operation_d;
    logic             illegal_q, illegal_d;

    logic [4:0] dec_code;
    logic       dec_mul, dec_div, dec_ill, dec_multi, accept;

    // Register-register / register-immediate ALU op selected by funct3 alone.
    function automatic logic [4:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    // Decode the presented instruction fields into an operation code.
    always_comb begin
        dec_code = OP_ILL;
        dec_mul  = 1'b0;
        dec_div  = 1'b0;
        case (alu_op)
            2'b00: dec_code = OP_ADD;
            2'b11: dec_code = OP_PASS;
            2'b01: begin
                case (funct3)
                    3'b000:  dec_code = OP_BEQ;
                    3'b001:  dec_code = OP_BNE;
                    3'b100:  dec_code = OP_BLT;
                    3'b101:  dec_code = OP_BGE;
                    3'b110:  dec_code = OP_BLTU;
                    3'b111:  dec_code = OP_BGEU;
                    default: dec_code = OP_ILL;
                endcase
            end
            default: begin
                if (is_imm) begin
                    // funct7 is immediate data except for the shift encodings.
                    case (funct3)
                        3'b001:  dec_code = (funct7 == F7_BASE) ? OP_SLL : OP_ILL;
                        3'b101: begin
                            if (funct7 == F7_BASE)     dec_code = OP_SRL;
                            else if (funct7 == F7_ALT) dec_code = OP_SRA;
                            else                       dec_code = OP_ILL;
                        end
                        default: dec_code = base_op(funct3);
                    endcase
                end else if (funct7 == F7_BASE) begin
                    dec_code = base_op(funct3);
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)      dec_code = OP_SUB;
                    else if (funct3 == 3'b101) dec_code = OP_SRA;
                    else                       dec_code = OP_ILL;
`ifdef ALU_CTRL_M_EXT_EN
                end else if (funct7 == F7_MEXT) begin
                    // MUL..REMU occupy 0x10..0x17 in funct3 order.
                    dec_code = {2'b10, funct3};
                    dec_mul  = ~funct3[2];
                    dec_div  = funct3[2];
`endif
                end else begin
                    dec_code = OP_ILL;
                end
            end
        endcase
    end

    assign dec_ill   = (dec_code == OP_ILL);
    assign dec_multi = dec_div | (dec_mul & MUL_MULTI);
    assign in_ready  = (state_q == IDLE);
    assign stall     = (state_q == BUSY);
    assign accept    = in_valid & in_ready & ~flush;

    // Next-state, countdown and result register updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mc_start_d  = 1'b0;
        op_valid_d  = 1'b0;
        operation_d = operation_q;
        illegal_d   = illegal_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    operation_d = dec_code;
                    illegal_d   = dec_ill;
                    if (dec_multi) begin
                        state_d    = BUSY;
                        cnt_d      = dec_div ? DIV_LOAD : MUL_LOAD;
                        mc_start_d = 1'b1;
                    end else begin
                        op_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                // operation_q is left untouched so it stays stable while busy.
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d    = IDLE;
                    op_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    // State, counter and registered outputs with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mc_start_q  <= 1'b0;
            op_valid_q  <= 1'b0;
            operation_q <= OP_ILL;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mc_start_q  <= mc_start_d;
            op_valid_q  <= op_valid_d;
            operation_q <= operation_d;
            illegal_q   <= illegal_d;
        end
    end

    assign mc_start  = mc_start_q;
    assign op_valid  = op_valid_q;
    assign illegal   = illegal_q;
    assign operation = OP_W'(operation_q);

endmodule
